// File: rtl/misr_chk_pkg.sv
// Shared types and helpers for the MISR response checker.
// Holds the FSM state type and the MISR next-value function.
package misr_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } chk_state_e;

  localparam int MISR_MAX_W = 64;

  typedef logic [MISR_MAX_W-1:0] misr_word_t;

  localparam logic [15:0] DEF_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  // One MISR step: shift left, fold in POLY when the MSB falls out,
  // then XOR in the observation bits. Caller truncates to its width.
  function automatic misr_word_t misr_step(
    input misr_word_t sig,
    input misr_word_t obs,
    input misr_word_t poly,
    input logic [5:0] msb
  );
    misr_word_t nxt;
    nxt = (sig << 1) ^ obs;
    if (sig[msb]) nxt = nxt ^ poly;
    return nxt;
  endfunction

endpackage

// File: rtl/misr_response_checker_if.sv
// Sequencer/observation bundle for the MISR response checker.
// master = harness side, slave = checker side.
interface misr_response_checker_if #(
  parameter int OBS_W = 1,
  parameter int SIG_W = 16,
  parameter int CNT_W = 10
);
  logic             start;
  logic             abort;
  logic             obs_valid;
  logic [OBS_W-1:0] obs_in;
  logic [SIG_W-1:0] golden_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic             trojan_flag;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] sample_count;

  modport master (
    output start, abort, obs_valid, obs_in, golden_sig,
    input  busy, done, pass, trojan_flag, signature, sample_count
  );

  modport slave (
    input  start, abort, obs_valid, obs_in, golden_sig,
    output busy, done, pass, trojan_flag, signature, sample_count
  );
endinterface

// File: rtl/misr_reg.sv
// Signature register with seed load and MISR shift.
// Load has priority over shift; otherwise the value holds.
module misr_reg
  import misr_chk_pkg::*;
#(
  parameter int               OBS_W = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [OBS_W-1:0] obs_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q, sig_d;

  // next signature: seed, one MISR step, or hold
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (shift_i) begin
      sig_d = SIG_W'(misr_step(
        MISR_MAX_W'(sig_q),
        MISR_MAX_W'(obs_i),
        MISR_MAX_W'(POLY),
        6'(SIG_W-1)));
    end
  end

  // signature register, synchronous reset to seed
  always_ff @(posedge clk_i) begin
    if (rst_i) sig_q <= SEED;
    else       sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/misr_response_checker.sv
// Compacts observation bits over a fixed window into a MISR
// signature and flags a trojan when it differs from golden.
module misr_response_checker
  import misr_chk_pkg::*;
#(
  parameter int               OBS_W  = 1,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter int               CYCLES = 1000,
  parameter int               CNT_W  = 10
) (
  input logic I1470,
  input logic I1477,
  misr_response_checker_if.slave bus
);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             troj_q, troj_d;
  logic             load, shift;
  logic [SIG_W-1:0] sig;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  misr_reg #(
    .OBS_W (OBS_W),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk_i   (I1470),
    .rst_i   (I1477),
    .load_i  (load),
    .shift_i (shift),
    .obs_i   (bus.obs_in),
    .sig_o   (sig)
  );

  // window sequencing; abort beats start and obs_valid
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    troj_d  = troj_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
      troj_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (bus.start) begin
            state_d = ST_RUN;
            load    = 1'b1;
            cnt_d   = '0;
            pass_d  = 1'b0;
            troj_d  = 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.obs_valid) begin
            shift = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          pass_d  = (sig == bus.golden_sig);
          troj_d  = (sig != bus.golden_sig);
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state, counter and result flags
  always_ff @(posedge I1470) begin
    if (I1477) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      troj_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      troj_q  <= troj_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN) ||
                    (state_q == ST_COMPARE);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.pass         = pass_q;
  assign bus.trojan_flag  = troj_q;
  assign bus.signature    = sig;
  assign bus.sample_count = cnt_q;

endmodule

// File: tb/tb_misr_response_checker.sv
// Directed bench for misr_response_checker.
// SIG_W=4, POLY=9, SEED=0, CYCLES=4.
module tb_misr_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  misr_response_checker_if #(
    .OBS_W(1), .SIG_W(4), .CNT_W(3)
  ) bus ();

  misr_response_checker #(
    .OBS_W  (1),
    .SIG_W  (4),
    .POLY   (4'h9),
    .SEED   (4'h0),
    .CYCLES (4),
    .CNT_W  (3)
  ) dut (
    .I1470 (clk),
    .I1477 (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    bus.obs_valid = 1'b1;
    bus.obs_in    = b;
    tick();
    bus.obs_valid = 1'b0;
  endtask

  task automatic begin_window();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.busy, bus.done, bus.pass, bus.trojan_flag} !== 4'b0000) begin
      $display("FAIL reset_flags got %b want 0000",
        {bus.busy, bus.done, bus.pass, bus.trojan_flag});
      n_fail++;
    end
    n_tests++;
    if (bus.signature !== 4'h0 || bus.sample_count !== 3'd0) begin
      $display("FAIL reset_state got sig=%h cnt=%0d want sig=0 cnt=0",
        bus.signature, bus.sample_count);
      n_fail++;
    end
  endtask

  task automatic test_basic_match();
    int c0;
    int lat;
    bus.golden_sig = 4'hB;
    begin_window();
    c0 = cyc;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.signature !== 4'h0) begin
      $display("FAIL match_start got busy=%b sig=%h want busy=1 sig=0",
        bus.busy, bus.signature);
      n_fail++;
    end
    send(1'b1);
    n_tests++;
    if (bus.signature !== 4'h1) begin
      $display("FAIL match_s1 got %h want 1", bus.signature);
      n_fail++;
    end
    send(1'b0);
    n_tests++;
    if (bus.signature !== 4'h2) begin
      $display("FAIL match_s2 got %h want 2", bus.signature);
      n_fail++;
    end
    send(1'b1);
    n_tests++;
    if (bus.signature !== 4'h5) begin
      $display("FAIL match_s3 got %h want 5", bus.signature);
      n_fail++;
    end
    send(1'b1);
    n_tests++;
    if (bus.signature !== 4'hB || bus.sample_count !== 3'd4 ||
        bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL match_s4 got sig=%h cnt=%0d done=%b busy=%b want B 4 0 1",
        bus.signature, bus.sample_count, bus.done, bus.busy);
      n_fail++;
    end
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    lat = cyc - c0;
    n_tests++;
    if (bus.done !== 1'b1 || lat !== 5) begin
      $display("FAIL match_latency got done=%b cycles=%0d want 1 5",
        bus.done, lat);
      n_fail++;
    end
    n_tests++;
    if (bus.pass !== 1'b1 || bus.trojan_flag !== 1'b0) begin
      $display("FAIL match_flags got pass=%b troj=%b want 1 0",
        bus.pass, bus.trojan_flag);
      n_fail++;
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pass !== 1'b1) begin
      $display("FAIL match_after got done=%b busy=%b pass=%b want 0 0 1",
        bus.done, bus.busy, bus.pass);
      n_fail++;
    end
  endtask

  task automatic test_mismatch();
    bus.golden_sig = 4'hA;
    begin_window();
    send(1'b1);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    n_tests++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b0 ||
        bus.trojan_flag !== 1'b1 || bus.signature !== 4'hB) begin
      $display("FAIL mismatch got done=%b pass=%b troj=%b sig=%h want 1 0 1 B",
        bus.done, bus.pass, bus.trojan_flag, bus.signature);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_gaps();
    int c0;
    int lat;
    bus.golden_sig = 4'hB;
    begin_window();
    c0 = cyc;
    send(1'b1);
    send(1'b0);
    tick();
    tick();
    tick();
    n_tests++;
    if (bus.signature !== 4'h2 || bus.sample_count !== 3'd2) begin
      $display("FAIL gap_hold got sig=%h cnt=%0d want 2 2",
        bus.signature, bus.sample_count);
      n_fail++;
    end
    send(1'b1);
    send(1'b1);
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    lat = cyc - c0;
    n_tests++;
    if (bus.done !== 1'b1 || lat !== 8 ||
        bus.signature !== 4'hB || bus.pass !== 1'b1) begin
      $display("FAIL gap_result got done=%b cycles=%0d sig=%h pass=%b want 1 8 B 1",
        bus.done, lat, bus.signature, bus.pass);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.golden_sig = 4'hB;
    begin_window();
    send(1'b1);
    send(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.signature !== 4'h0 ||
        bus.sample_count !== 3'd0 || bus.pass !== 1'b0) begin
      $display("FAIL rst_mid got busy=%b sig=%h cnt=%0d pass=%b want 0 0 0 0",
        bus.busy, bus.signature, bus.sample_count, bus.pass);
      n_fail++;
    end
    begin_window();
    send(1'b1);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    n_tests++;
    if (bus.done !== 1'b1 || bus.signature !== 4'hB || bus.pass !== 1'b1) begin
      $display("FAIL rst_fresh got done=%b sig=%h pass=%b want 1 B 1",
        bus.done, bus.signature, bus.pass);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_start_in_run();
    bus.golden_sig = 4'hB;
    begin_window();
    send(1'b1);
    bus.start = 1'b1;
    send(1'b0);
    bus.start = 1'b0;
    n_tests++;
    if (bus.signature !== 4'h2 || bus.sample_count !== 3'd2) begin
      $display("FAIL start_ignored got sig=%h cnt=%0d want 2 2",
        bus.signature, bus.sample_count);
      n_fail++;
    end
    send(1'b1);
    send(1'b1);
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    n_tests++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin
      $display("FAIL start_ignored_end got done=%b pass=%b want 1 1",
        bus.done, bus.pass);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_abort();
    int seen;
    test_mismatch();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_tests++;
    if (bus.trojan_flag !== 1'b0 || bus.signature !== 4'hB) begin
      $display("FAIL abort_idle got troj=%b sig=%h want 0 B",
        bus.trojan_flag, bus.signature);
      n_fail++;
    end
    begin_window();
    send(1'b1);
    send(1'b0);
    send(1'b1);
    bus.abort     = 1'b1;
    bus.start     = 1'b1;
    bus.obs_valid = 1'b1;
    bus.obs_in    = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.start     = 1'b0;
    bus.obs_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1;
      tick();
    end
    n_tests++;
    if (seen !== 0) begin
      $display("FAIL abort_nodone got done/busy seen=%0d want 0", seen);
      n_fail++;
    end
    n_tests++;
    if (bus.signature !== 4'h5 || bus.sample_count !== 3'd3 ||
        bus.pass !== 1'b0 || bus.trojan_flag !== 1'b0) begin
      $display("FAIL abort_hold got sig=%h cnt=%0d pass=%b troj=%b want 5 3 0 0",
        bus.signature, bus.sample_count, bus.pass, bus.trojan_flag);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    bus.golden_sig = 4'hB;
    begin_window();
    send(1'b1);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.signature !== 4'h0 ||
        bus.sample_count !== 3'd0 || bus.pass !== 1'b0) begin
      $display("FAIL b2b_start got busy=%b done=%b sig=%h cnt=%0d pass=%b want 1 0 0 0 0",
        bus.busy, bus.done, bus.signature, bus.sample_count, bus.pass);
      n_fail++;
    end
    bus.golden_sig = 4'h3;
    send(1'b0);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    n_tests++;
    if (bus.done !== 1'b1 || bus.signature !== 4'h3 || bus.pass !== 1'b1) begin
      $display("FAIL b2b_second got done=%b sig=%h pass=%b want 1 3 1",
        bus.done, bus.signature, bus.pass);
      n_fail++;
    end
    tick();
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.obs_valid  = 1'b0;
    bus.obs_in     = 1'b0;
    bus.golden_sig = 4'h0;
    test_reset();
    test_basic_match();
    test_mismatch();
    test_gaps();
    test_reset_mid();
    test_start_in_run();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
